// File: rtl/debug_capture_ctrl.sv
// Debug capture controller: arms on a CTRL write, records qualified probe
// samples into a circular buffer, fires on a masked compare and keeps a
// programmable number of post-trigger samples, then exposes the buffer
// oldest-first through a register read port.
module debug_capture_ctrl #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32
) (
    input  logic             msoc_clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] probe_data,
    input  logic             probe_valid,
    input  logic             cfg_ce,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_addr,
    input  logic [31:0]      cfg_wdata,
    output logic [31:0]      cfg_rdata,
    output logic             busy,
    output logic             done,
    output logic             trig_out
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] mask, value;
    logic [AW-1:0]    post, rdptr, wr_ptr, post_cnt, trig_idx, rd_addr;
    logic [AW:0]      fill;
    logic             wr_ctrl, arm_req, abort_req, hit, full, sample_en, rd_req;
    logic [31:0]      rd_mux;

    // Access decode, trigger compare and buffer read addressing
    always_comb begin
        wr_ctrl   = cfg_ce & cfg_we & (cfg_addr == 3'd0);
        abort_req = wr_ctrl & cfg_wdata[1];
        arm_req   = wr_ctrl & cfg_wdata[0] & ~cfg_wdata[1];
        hit       = probe_valid & ((probe_data & mask) == (value & mask));
        full      = fill[AW];
        sample_en = probe_valid & busy & ~abort_req;
        rd_req    = cfg_ce & ~cfg_we;
        rd_addr   = full ? (wr_ptr + rdptr) : rdptr;
    end

    // State register
    always_ff @(posedge msoc_clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; abort overrides everything
    always_comb begin
        state_nxt = state;
        if (abort_req) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (arm_req) state_nxt = S_ARMED;
                S_ARMED:        if (hit) state_nxt = (post == '0) ? S_DONE : S_CAPTURE;
                S_CAPTURE:      if (probe_valid && post_cnt == AW'(1)) state_nxt = S_DONE;
                default:        state_nxt = S_IDLE;
            endcase
        end
    end

    // Status outputs decoded from state
    always_comb begin
        busy = (state == S_ARMED) || (state == S_CAPTURE);
        done = (state == S_DONE);
    end

    // Capture pointers, fill level, trigger position and post-trigger count.
    // trig_idx is kept in oldest-first order, so once the buffer is full it
    // slides down by one for every post-trigger overwrite of the oldest entry.
    always_ff @(posedge msoc_clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            fill     <= '0;
            trig_idx <= '0;
            post_cnt <= '0;
            trig_out <= 1'b0;
        end else begin
            trig_out <= (state == S_ARMED) & hit & ~abort_req;
            if (arm_req && (state == S_IDLE || state == S_DONE)) begin
                wr_ptr   <= '0;
                fill     <= '0;
                trig_idx <= '0;
            end else if (sample_en) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (!full) fill <= fill + (AW+1)'(1);
                if (state == S_ARMED && hit) begin
                    trig_idx <= full ? '1 : fill[AW-1:0];
                    post_cnt <= post;
                end else if (state == S_CAPTURE) begin
                    post_cnt <= post_cnt - AW'(1);
                    if (full) trig_idx <= trig_idx - AW'(1);
                end
            end
        end
    end

    // Sample buffer write port
    always_ff @(posedge msoc_clk) begin
        if (sample_en && !rst) mem[wr_ptr] <= probe_data;
    end

    // Register read multiplexer
    always_comb begin
        rd_mux = '0;
        case (cfg_addr)
            3'd1: rd_mux = {16'(trig_idx), 14'(fill), state};
            3'd2: rd_mux = 32'(mask);
            3'd3: rd_mux = 32'(value);
            3'd4: rd_mux = 32'(post);
            3'd5: rd_mux = 32'(rdptr);
            3'd6: if (!busy && ({1'b0, rdptr} < fill)) rd_mux = 32'(mem[rd_addr]);
            default: rd_mux = '0;
        endcase
    end

    // Configuration registers, read-pointer advance and registered read data
    always_ff @(posedge msoc_clk) begin
        if (rst) begin
            mask      <= '0;
            value     <= '0;
            post      <= '0;
            rdptr     <= '0;
            cfg_rdata <= '0;
        end else begin
            if (cfg_ce && cfg_we) begin
                case (cfg_addr)
                    3'd2: if (!busy) mask  <= WIDTH'(cfg_wdata);
                    3'd3: if (!busy) value <= WIDTH'(cfg_wdata);
                    3'd4: if (!busy) post  <= cfg_wdata[AW-1:0];
                    3'd5: rdptr <= cfg_wdata[AW-1:0];
                    default: ;
                endcase
            end
            if (rd_req) begin
                cfg_rdata <= rd_mux;
                if (cfg_addr == 3'd6 && !busy) rdptr <= rdptr + AW'(1);
            end
        end
    end

endmodule

// File: tb/tb_debug_capture_ctrl.sv
// Directed bench for debug_capture_ctrl with a queue-based buffer model and
// a read scoreboard (expected read data queued at the strobe, checked one
// cycle later).
module tb_debug_capture_ctrl;

    localparam int DEPTH = 16;

    logic        msoc_clk = 1'b0;
    logic        rst;
    logic [31:0] probe_data;
    logic        probe_valid;
    logic        cfg_ce, cfg_we;
    logic [2:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        busy, done, trig_out;

    debug_capture_ctrl #(.DEPTH(DEPTH), .WIDTH(32)) dut (
        .msoc_clk   (msoc_clk),
        .rst        (rst),
        .probe_data (probe_data),
        .probe_valid(probe_valid),
        .cfg_ce     (cfg_ce),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_rdata  (cfg_rdata),
        .busy       (busy),
        .done       (done),
        .trig_out   (trig_out)
    );

    always #5 msoc_clk = ~msoc_clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    // Reference model state
    logic [31:0] m_buf[$];
    int          m_state, m_post_cnt, m_trig, m_post, m_rdptr;
    logic [31:0] m_mask, m_value;

    function automatic bit m_busy();
        return (m_state == 1) || (m_state == 2);
    endfunction

    function automatic logic [31:0] m_status();
        return (32'(m_trig) << 16) | (32'(m_buf.size()) << 2) | 32'(m_state);
    endfunction

    task automatic model_reset();
        m_buf.delete();
        m_state = 0; m_post_cnt = 0; m_trig = 0; m_post = 0; m_rdptr = 0;
        m_mask = '0; m_value = '0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; any read strobed this cycle is scored after the edge
    task automatic tick();
        bit          was_rd;
        logic [31:0] e;
        string       t;
        was_rd = cfg_ce && !cfg_we && !rst;
        @(posedge msoc_clk);
        #1;
        if (was_rd) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL scoreboard_empty observed=0x%0h expected=none", cfg_rdata);
            end else begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                chk(t, cfg_rdata, e);
            end
        end
    endtask

    task automatic wr(input logic [2:0] addr, input logic [31:0] data);
        cfg_ce = 1'b1; cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
        tick();
        cfg_ce = 1'b0; cfg_we = 1'b0;
        case (addr)
            3'd0: if (data[1]) m_state = 0;
                  else if (data[0] && (m_state == 0 || m_state == 3)) begin
                      m_state = 1; m_buf.delete(); m_trig = 0;
                  end
            3'd2: if (!m_busy()) m_mask = data;
            3'd3: if (!m_busy()) m_value = data;
            3'd4: if (!m_busy()) m_post = int'(data) % DEPTH;
            3'd5: m_rdptr = int'(data) % DEPTH;
            default: ;
        endcase
    endtask

    task automatic rd_x(input logic [2:0] addr, input string tag, input bit lit, input logic [31:0] litv);
        logic [31:0] e;
        e = '0;
        case (addr)
            3'd1: e = m_status();
            3'd2: e = m_mask;
            3'd3: e = m_value;
            3'd4: e = 32'(m_post);
            3'd5: e = 32'(m_rdptr);
            3'd6: if (!m_busy()) begin
                      e = (m_rdptr < m_buf.size()) ? m_buf[m_rdptr] : '0;
                      m_rdptr = (m_rdptr + 1) % DEPTH;
                  end
            default: e = '0;
        endcase
        exp_q.push_back(lit ? litv : e);
        tag_q.push_back(tag);
        cfg_ce = 1'b1; cfg_we = 1'b0; cfg_addr = addr;
        tick();
        cfg_ce = 1'b0;
    endtask

    task automatic rd(input logic [2:0] addr, input string tag);
        rd_x(addr, tag, 1'b0, '0);
    endtask

    task automatic feed(input logic [31:0] d, input bit v);
        bit trg;
        trg = 1'b0;
        probe_data = d; probe_valid = v;
        if (v && m_busy()) begin
            if (m_buf.size() == DEPTH) begin
                void'(m_buf.pop_front());
                if (m_state == 2) m_trig--;
            end
            m_buf.push_back(d);
            if (m_state == 1) begin
                if ((d & m_mask) == (m_value & m_mask)) begin
                    trg = 1'b1;
                    m_trig = m_buf.size() - 1;
                    if (m_post == 0) m_state = 3;
                    else begin m_state = 2; m_post_cnt = m_post; end
                end
            end else begin
                m_post_cnt--;
                if (m_post_cnt == 0) m_state = 3;
            end
        end
        tick();
        probe_valid = 1'b0;
        chk("trig_out", 32'(trig_out), 32'(trg));
        chk("busy", 32'(busy), 32'(m_busy()));
        chk("done", 32'(done), 32'(m_state == 3));
    endtask

    // Reset is held with a MASK write strobed; that write must be dropped
    task automatic do_reset();
        rst = 1'b1; cfg_ce = 1'b1; cfg_we = 1'b1; cfg_addr = 3'd2; cfg_wdata = 32'hFFFF;
        tick();
        tick();
        rst = 1'b0; cfg_ce = 1'b0; cfg_we = 1'b0;
        model_reset();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_trig_out", 32'(trig_out), 32'd0);
        chk("rst_rdata", cfg_rdata, 32'd0);
    endtask

    initial begin
        rst = 1'b1; probe_data = '0; probe_valid = 1'b0;
        cfg_ce = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        model_reset();

        do_reset();
        rd(3'd1, "rst_status");
        rd(3'd2, "rst_mask");
        rd(3'd4, "rst_post");
        rd(3'd5, "rst_rdptr");

        // Exact-match trigger on 0x5A with three post-trigger samples
        wr(3'd2, 32'hFF); wr(3'd3, 32'h5A); wr(3'd4, 32'd3); wr(3'd0, 32'd1);
        chk("armed_busy", 32'(busy), 32'd1);
        for (int d = 'h10; d <= 'h5D; d++) feed(32'(d), 1'b1);
        rd_x(3'd1, "s1_status", 1'b1, {16'd12, 14'd16, 2'd3});
        wr(3'd5, 32'd0);
        for (int i = 0; i < 17; i++) rd(3'd6, "s1_rddata");

        // Wrapped buffer: trigger at 35, four post samples
        wr(3'd3, 32'd35); wr(3'd4, 32'd4); wr(3'd0, 32'd1);
        for (int d = 0; d < 40; d++) feed(32'(d), 1'b1);
        feed(32'd40, 1'b1);
        rd_x(3'd1, "s2_status", 1'b1, {16'd11, 14'd16, 2'd3});
        wr(3'd5, 32'd0);
        rd_x(3'd6, "s2_first", 1'b1, 32'd24);
        for (int i = 1; i < 16; i++) rd(3'd6, "s2_rddata");

        // MASK=0, POST=0: first valid sample ends the capture
        wr(3'd2, 32'd0); wr(3'd4, 32'd0); wr(3'd0, 32'd1);
        feed(32'h7, 1'b0);
        feed(32'h7, 1'b1);
        rd_x(3'd1, "s3_status", 1'b1, {16'd0, 14'd1, 2'd3});
        wr(3'd5, 32'd0);
        rd_x(3'd6, "s3_rd0", 1'b1, 32'h7);
        rd_x(3'd6, "s3_rd1", 1'b1, 32'h0);

        // Post-trigger samples with probe_valid toggling
        wr(3'd2, 32'hFF); wr(3'd3, 32'h80); wr(3'd4, 32'd2); wr(3'd0, 32'd1);
        feed(32'h7E, 1'b1); feed(32'h7F, 1'b1); feed(32'h80, 1'b1);
        feed(32'h80, 1'b0); feed(32'h90, 1'b1); feed(32'h11, 1'b0); feed(32'h91, 1'b1);
        feed(32'h92, 1'b1);
        rd_x(3'd1, "s4_status", 1'b1, {16'd2, 14'd5, 2'd3});
        wr(3'd5, 32'd0);
        for (int i = 0; i < 6; i++) rd(3'd6, "s4_rddata");

        // Busy protections, ARM ignored while armed, abort, reset mid-capture
        wr(3'd0, 32'd1);
        feed(32'h1, 1'b1); feed(32'h2, 1'b1);
        wr(3'd2, 32'h0);
        feed(32'h55, 1'b1);
        rd_x(3'd2, "s5_mask_kept", 1'b1, 32'hFF);
        rd_x(3'd6, "s5_busy_rddata", 1'b1, 32'h0);
        rd(3'd5, "s5_busy_rdptr");
        wr(3'd0, 32'd1);
        rd(3'd1, "s5_rearm_ignored");
        wr(3'd0, 32'd3);
        chk("s5_abort_busy", 32'(busy), 32'd0);
        rd(3'd1, "s5_abort_status");
        wr(3'd0, 32'd1);
        feed(32'h80, 1'b1);
        do_reset();
        rd(3'd1, "s5_rst_status");
        rd(3'd2, "s5_rst_mask");
        rd(3'd3, "s5_rst_value");
        rd(3'd4, "s5_rst_post");
        rd(3'd5, "s5_rst_rdptr");

        // Back-to-back STATUS then RDDATA reads
        wr(3'd0, 32'd1);
        feed(32'hAB, 1'b1);
        wr(3'd5, 32'd0);
        rd(3'd1, "b2b_status");
        rd_x(3'd6, "b2b_rddata", 1'b1, 32'hAB);
        rd_x(3'd5, "b2b_rdptr", 1'b1, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/debug_capture_ctrl.md
DEBUG_CAPTURE_CTRL -- requirements
Module: debug_capture_ctrl

Interface
REQ-001 SHALL provide parameter DEPTH, default 256, sample buffer depth (power of two, 16..4096).
REQ-002 SHALL provide parameter WIDTH, default 32, probe sample width; AW = log2(DEPTH).
REQ-003 SHALL have port msoc_clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port probe_data  input  WIDTH  sample under observation.
REQ-006 SHALL have port probe_valid  input  1  probe_data qualifier; one sample per high cycle.
REQ-007 SHALL have port cfg_ce  input  1  register access strobe.
REQ-008 SHALL have port cfg_we  input  1  1 = write, 0 = read (with cfg_ce).
REQ-009 SHALL have port cfg_addr  input  3  word register index.
REQ-010 SHALL have port cfg_wdata  input  32  write data.
REQ-011 SHALL have port cfg_rdata  output  32  registered read data.
REQ-012 SHALL have ports busy, done, trig_out  output  1 each  status (REQ-024).

Function
REQ-013 Registers SHALL be: 0 CTRL (W: bit0 ARM, bit1 ABORT; reads 0); 1 STATUS (R: [1:0] state, [15:2] fill, [31:16] trig_idx); 2 MASK; 3 VALUE; 4 POST [AW-1:0]; 5 RDPTR [AW-1:0]; 6 RDDATA (R); 7 reserved (reads 0, writes ignored).
REQ-014 Reads SHALL have one-cycle latency: cfg_rdata updates on the edge after cfg_ce & !cfg_we and holds otherwise.
REQ-015 State machine SHALL be IDLE(0), ARMED(1), CAPTURE(2), DONE(3).
REQ-016 Trigger SHALL be probe_valid & ((probe_data & MASK) == (VALUE & MASK)); MASK=0 fires on first valid sample.
REQ-017 IDLE/DONE + ARM write -> ARMED; wr_ptr, fill, trig_idx SHALL clear to 0 the same edge.
REQ-018 ARMED: each valid sample SHALL be written at wr_ptr, wr_ptr wraps mod DEPTH, fill increments saturating at DEPTH.
REQ-019 ARMED + trigger sample: sample written, trig_idx := fill before increment, post_cnt := POST; next state DONE if POST==0 else CAPTURE.
REQ-020 CAPTURE: each valid sample written, post_cnt decrements; sample taking post_cnt to 0 -> DONE.
REQ-021 DONE/IDLE: no buffer writes; probe inputs ignored.
REQ-022 ABORT write SHALL force IDLE from any state next edge; ARM and ABORT together: ABORT wins; ARM in ARMED/CAPTURE ignored.
REQ-023 Writes to MASK, VALUE, POST while busy SHALL be ignored; RDPTR writable anytime.
REQ-024 busy = state in {ARMED, CAPTURE}; done = state==DONE; trig_out = one-cycle pulse the cycle after the trigger sample edge.
REQ-025 RDDATA read SHALL return buffer[i] when fill<DEPTH, else buffer[(wr_ptr+i) mod DEPTH], i = RDPTR (oldest first); i >= fill returns 0; RDPTR then post-increments mod DEPTH.
REQ-026 RDDATA reads in ARMED/CAPTURE SHALL return 0 and not advance RDPTR.
REQ-027 Buffer SHALL be single-port-write synchronous RAM inferable on Xilinx 7-series; WIDTH>32 reads return low 32 bits.

Reset
REQ-028 On rst: state IDLE, busy 0, done 0, trig_out 0, cfg_rdata 0, MASK 0, VALUE 0, POST 0, RDPTR 0, wr_ptr 0, fill 0, trig_idx 0, post_cnt 0.
REQ-029 Buffer contents need not reset; rst mid-capture SHALL abandon capture with no further writes.
REQ-030 rst asserted with cfg_ce SHALL ignore the access.

Verification
REQ-031 MASK=FF, VALUE=5A, POST=3, ARM; feed 0x10..0x5A..0x5D contiguous -> trig_out pulse after 0x5A, done after 0x5D, fill = count fed, RDDATA yields 0x10.. in order, trig_idx points to 0x5A.
REQ-032 DEPTH=16, POST=4, feed 40 samples 0..39, trigger at 35 -> fill=16, RDDATA reads 24..39, trig_idx=11.
REQ-033 POST=0, MASK=0, ARM, first valid sample 0x7 -> DONE next edge, fill=1, RDDATA returns 0x7 then 0.
REQ-034 probe_valid toggled every other cycle during CAPTURE, POST=2 -> exactly 2 valid samples after trigger stored, invalid cycles ignored.
REQ-035 CTRL write 0x3 while ARMED -> IDLE, busy 0; MASK write while ARMED ignored; rst in CAPTURE -> all REQ-028 values.
REQ-036 Read STATUS then RDDATA back-to-back -> each cfg_rdata one cycle after its strobe, RDPTR advances once.
